fp_normalize64: RTL



---
 rtl/fp_normalize64.sv | 125 ++++++++++++
 1 files changed

// File: rtl/fp_normalize64.sv
`default_nettype none
// ============================================================================
// Module   : fp_normalize64
// Purpose  : Normalizes and packs a raw 53-bit adder significand into binary64,
//            one left shift per enabled cycle, truncating rounding.
// Revision : 1.0 - initial release
// ============================================================================
module fp_normalize64 (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        load,
   input  logic [52:0] sum,
   input  logic        c_in,
   input  logic        sign,
   input  logic [10:0] exp_in,
   output logic [63:0] result,
   output logic        ready,
   output logic        busy,
   output logic        overflow
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_NORM = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [11:0] C_EXP_MAX = 12'd2047;

   state_t      state_q, state_d;
   logic [52:0] mant_q, mant_d;
   logic [11:0] exp_q, exp_d;
   logic        s_q, s_d;
   logic [63:0] result_q, result_d;
   logic        ready_q, ready_d;
   logic        busy_q, busy_d;
   logic        ovf_q, ovf_d;
   logic [11:0] exp_eff;

   // A zero exponent field encodes the subnormal scale, which equals exponent 1.
   assign exp_eff = (exp_in == 11'd0) ? 12'd1 : {1'b0, exp_in};

   always_comb begin
      state_d  = state_q;
      mant_d   = mant_q;
      exp_d    = exp_q;
      s_d      = s_q;
      result_d = result_q;
      ready_d  = ready_q;
      busy_d   = busy_q;
      ovf_d    = ovf_q;

      if (load) begin
         if (c_in) begin
            mant_d = {1'b1, sum[52:1]};
            exp_d  = exp_eff + 12'd1;
         end else begin
            mant_d = sum;
            exp_d  = exp_eff;
         end
         s_d     = sign;
         ready_d = 1'b0;
         ovf_d   = 1'b0;
         busy_d  = 1'b1;
         state_d = ST_NORM;
      end else if (state_q == ST_NORM) begin
         if (exp_q >= C_EXP_MAX) begin
            result_d = {s_q, 11'h7FF, 52'h0};
            ovf_d    = 1'b1;
            ready_d  = 1'b1;
            busy_d   = 1'b0;
            state_d  = ST_DONE;
         end else if (mant_q == 53'd0) begin
            result_d = 64'h0;
            ready_d  = 1'b1;
            busy_d   = 1'b0;
            state_d  = ST_DONE;
         end else if (mant_q[52]) begin
            result_d = {s_q, exp_q[10:0], mant_q[51:0]};
            ready_d  = 1'b1;
            busy_d   = 1'b0;
            state_d  = ST_DONE;
         end else if (exp_q <= 12'd1) begin
            // Cannot shift further without dropping below the minimum exponent.
            result_d = {s_q, 11'h000, mant_q[51:0]};
            ready_d  = 1'b1;
            busy_d   = 1'b0;
            state_d  = ST_DONE;
         end else begin
            mant_d = {mant_q[51:0], 1'b0};
            exp_d  = exp_q - 12'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         mant_q   <= 53'd0;
         exp_q    <= 12'd0;
         s_q      <= 1'b0;
         result_q <= 64'h0;
         ready_q  <= 1'b0;
         busy_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else if (en) begin
         state_q  <= state_d;
         mant_q   <= mant_d;
         exp_q    <= exp_d;
         s_q      <= s_d;
         result_q <= result_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
         ovf_q    <= ovf_d;
      end
   end

   assign result   = result_q;
   assign ready    = ready_q;
   assign busy     = busy_q;
   assign overflow = ovf_q;

endmodule
`default_nettype wire
